mips32_icache: RTL and testbench
================================

Name: mips32_icache

Overview:
- Parametrised, direct-mapped, word-addressed instruction cache between the MIPS32 fetch stage and the instruction memory (`Mem`).
- Returns hit data one cycle after a request is accepted.
- On a miss, refills a whole line from memory using a per-beat req/ack handshake, then returns the requested word.
- Provides a single-cycle flush that invalidates every line; it replaces testbench-style cache initialisation.

Parameters:
- ADDR_W, 32, word address width.
- DATA_W, 32, instruction word width.
- LINES, 16, number of cache lines; power of 2, ≥2.
- WORDS_PER_LINE, 4, words per line; power of 2, ≥2.

Ports:
- clk1  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_addr  in  ADDR_W  word address of the instruction.
- req_ready  out  1  cache can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse; resp_data is valid.
- resp_data  out  DATA_W  instruction word.
- flush  in  1  invalidate all lines.
- mem_req  out  1  memory read request for one word.
- mem_addr  out  ADDR_W  word address of the current refill beat.
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  DATA_W  refill word.

Behaviour:
- Address split: OFF_W = log2(WORDS_PER_LINE), IDX_W = log2(LINES).
  - offset = req_addr[OFF_W-1:0].
  - index = next IDX_W bits.
  - tag = remaining upper bits.
- Storage:
  - data array LINES×WORDS_PER_LINE×DATA_W.
  - tag array LINES×(ADDR_W-OFF_W-IDX_W).
  - valid bit per line.
- Reset:
  - state=IDLE.
  - All valid bits cleared.
  - req_ready=0, resp_valid=0, resp_data=0, mem_req=0, mem_addr=0.
  - Beat counter=0.
  - Pending flush cleared.
  - Reset during REFILL aborts the refill: mem_req=0 on the next cycle and no partial line is marked valid.
- FSM states: IDLE, REFILL, RESP.
- IDLE:
  - req_ready = 1 unless flush=1 or a pending flush is being applied.
  - Accept a request when req_valid && req_ready; latch addr.
  - Hit (valid[index] && tag match): next cycle resp_valid=1 and resp_data=data[index][offset]. Stay in IDLE. req_ready stays high, so back-to-back hits give 1 word/cycle.
  - Miss: go to REFILL. req_ready=0 from the next cycle.
- REFILL:
  - mem_req=1 and mem_addr={tag,index,beat}, starting at beat 0.
  - mem_addr is held stable until mem_ack.
  - On mem_ack: write mem_rdata into data[index][beat] and increment beat.
  - A cycle with mem_req && !mem_ack is a wait; nothing changes.
  - Final beat (beat=WORDS_PER_LINE-1) with ack: write tag, set valid[index], go to RESP. mem_req=0 on the next cycle.
- RESP:
  - resp_valid=1 for one cycle with data[index][offset]; return to IDLE.
  - This is the same word the processor requested, even if a flush arrived mid-refill.
- Miss latency: accept → resp_valid = WORDS_PER_LINE beats (+ memory wait cycles) + 2 cycles.
- Flush:
  - In IDLE: all valid bits are cleared at the clock edge; no request is accepted that cycle.
  - In REFILL/RESP: flush sets a pending flag. The refill completes and responds, then the flag clears all valid bits on the first IDLE cycle, with req_ready=0 that cycle.
- Conflict: a request whose index equals a resident line with a different tag replaces that line. Direct-mapped, no LRU.
- Address wrap: tag/index/offset use pure bit slicing; address 2^ADDR_W-1 maps to the last line/word without special handling.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], incremented per accepted hit or miss.
  - Both counters saturate at 0xFFFFFFFF.
  - Cleared by reset; not cleared by flush.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss (defaults):
  - Stimulus: reset, then req_addr=0x00000005; memory acks every cycle with rdata=addr+0x100.
  - Required: mem_addr 4,5,6,7; then resp_valid with resp_data=0x105, 6 cycles after accept.
- Hit streak:
  - Stimulus: after the cold miss, requests 4,5,6,7 on consecutive cycles.
  - Required: resp_data 0x104..0x107 one cycle after each; req_ready never drops; mem_req stays 0.
- Conflict eviction:
  - Stimulus: req 0x45 (index 1, tag 1), then req 0x05.
  - Required: both miss; refill addresses 0x44..0x47, then 0x04..0x07; final resp_data=0x105.
- Wait states:
  - Stimulus: mem_ack asserted only every 3rd cycle during a refill of addr 0x20.
  - Required: mem_addr holds each value until acked; resp_data=0x120 after 12+2 cycles.
- Flush:
  - Stimulus: flush in IDLE, then req 0x05.
  - Required: req_ready=0 in the flush cycle; the request misses and refills.
  - Stimulus: flush mid-refill.
  - Required: the response is still delivered; the next req to the same line misses.
- Reset mid-refill:
  - Stimulus: assert reset after beat 1.
  - Required: mem_req=0 next cycle; a following req 0x05 misses.
  - With ICACHE_STATS_EN: hit/miss counters read 0 after reset.

Source files
------------

// File: rtl/mips32_icache.sv
// Direct-mapped, word-addressed MIPS32 instruction cache with line refill over a req/ack port.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module mips32_icache #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [DATA_W-1:0] data_q [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;

    logic [1:0]        state;
    logic [TAG_W-1:0]  a_tag;
    logic [IDX_W-1:0]  a_idx;
    logic [OFF_W-1:0]  a_off;
    logic [OFF_W-1:0]  beat;
    logic              flush_pend;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              hit;
    logic              accept;
    logic              last_ack;

    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_off  = req_addr[OFF_W-1:0];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // A pending flush owns the first IDLE cycle, so no request may slip in ahead of it.
    assign req_ready = !reset && (state == S_IDLE) && !flush && !flush_pend;
    assign accept    = req_valid && req_ready;
    assign last_ack  = (state == S_REFILL) && mem_ack && (beat == LAST_BEAT);

    assign mem_req  = (state == S_REFILL);
    assign mem_addr = mem_req ? {a_tag, a_idx, beat} : '0;

    always_ff @(posedge clk1) begin
        if (reset) begin
            state      <= S_IDLE;
            valid_q    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            beat       <= '0;
            flush_pend <= 1'b0;
            a_tag      <= '0;
            a_idx      <= '0;
            a_off      <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush || flush_pend) begin
                        valid_q    <= '0;
                        flush_pend <= 1'b0;
                    end else if (accept) begin
                        a_tag <= req_tag;
                        a_idx <= req_idx;
                        a_off <= req_off;
                        if (hit) begin
                            resp_valid <= 1'b1;
                            resp_data  <= data_q[req_idx][req_off];
                        end else begin
                            state <= S_REFILL;
                            beat  <= '0;
                        end
                    end
                end
                S_REFILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_ack) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            valid_q[a_idx] <= 1'b1;
                            state          <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (flush) flush_pend <= 1'b1;
                    resp_valid <= 1'b1;
                    resp_data  <= data_q[a_idx][a_off];
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line storage is not reset; a line only becomes visible through valid_q.
    always_ff @(posedge clk1) begin
        if ((state == S_REFILL) && mem_ack)
            data_q[a_idx][beat] <= mem_rdata;
        if (last_ack)
            tag_q[a_idx] <= a_tag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk1) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips32_icache.sv
// Directed bench for mips32_icache: a word memory answers refills with rdata = addr + 0x100.
module tb_mips32_icache;
    logic        clk1 = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int passed = 0;
    int total  = 0;
    int ack_div = 1;
    int wcnt = 0;
    logic [31:0] addr_log[$];
    logic [31:0] ack_log[$];

    mips32_icache dut (
        .clk1(clk1), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial forever #5 clk1 = ~clk1;

    // Memory: acks on every ack_div-th cycle of a request, logging every address it sees.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk1);
            if (mem_req) begin
                wcnt++;
                addr_log.push_back(mem_addr);
                if (wcnt >= ack_div) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_addr + 32'h100;
                    ack_log.push_back(mem_addr);
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    // Issues one request and returns cycles from accept to resp_valid (100 = timeout).
    task automatic do_req(input logic [31:0] a, output int lat, output logic [31:0] d);
        @(negedge clk1);
        req_valid = 1'b1;
        req_addr = a;
        @(negedge clk1);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(negedge clk1);
            lat++;
        end
        d = resp_data;
    endtask

    task automatic clear_logs();
        addr_log.delete();
        ack_log.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        repeat (2) @(negedge clk1);
        total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got %0b want 0", req_ready); else passed++;
        total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %0b want 0", resp_valid); else passed++;
        total++; if (resp_data !== 32'h0) $display("FAIL reset_resp_data got %h want 0", resp_data); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %0b want 0", mem_req); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else passed++;
`ifdef ICACHE_STATS_EN
        total++; if (hit_count !== 32'h0) $display("FAIL reset_hit_count got %0d want 0", hit_count); else passed++;
        total++; if (miss_count !== 32'h0) $display("FAIL reset_miss_count got %0d want 0", miss_count); else passed++;
`endif
        reset = 1'b0;
        @(negedge clk1);
        total++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready got %0b want 1", req_ready); else passed++;
    endtask

    task automatic test_cold_miss();
        int lat;
        logic [31:0] d;
        logic [31:0] exp_addr;
        clear_logs();
        do_req(32'h5, lat, d);
        total++; if (lat !== 6) $display("FAIL cold_latency got %0d want 6", lat); else passed++;
        total++; if (d !== 32'h105) $display("FAIL cold_data got %h want 00000105", d); else passed++;
        total++; if (ack_log.size() !== 4) $display("FAIL cold_beats got %0d want 4", ack_log.size()); else passed++;
        for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
            exp_addr = 32'h4 + i;
            total++; if (ack_log[i] !== exp_addr) $display("FAIL cold_mem_addr[%0d] got %h want %h", i, ack_log[i], exp_addr); else passed++;
        end
    endtask

    task automatic test_hit_streak();
        logic [31:0] exp;
        clear_logs();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk1);
            if (i > 0) begin
                exp = 32'h104 + i - 1;
                total++; if (resp_valid !== 1'b1 || resp_data !== exp)
                    $display("FAIL hit_resp[%0d] got v=%0b d=%h want v=1 d=%h", i - 1, resp_valid, resp_data, exp); else passed++;
            end
            if (i < 4) begin
                total++; if (req_ready !== 1'b1) $display("FAIL hit_req_ready[%0d] got %0b want 1", i, req_ready); else passed++;
                req_valid = 1'b1;
                req_addr = 32'h4 + i;
            end else begin
                req_valid = 1'b0;
            end
        end
        total++; if (addr_log.size() !== 0) $display("FAIL hit_mem_req got %0d beats want 0", addr_log.size()); else passed++;
    endtask

    task automatic test_conflict();
        int lat;
        logic [31:0] d;
        logic [31:0] exp_addr;
        clear_logs();
        do_req(32'h45, lat, d);
        total++; if (lat !== 6 || d !== 32'h145) $display("FAIL conflict_first got lat=%0d d=%h want lat=6 d=00000145", lat, d); else passed++;
        do_req(32'h05, lat, d);
        total++; if (lat !== 6 || d !== 32'h105) $display("FAIL conflict_second got lat=%0d d=%h want lat=6 d=00000105", lat, d); else passed++;
        total++; if (ack_log.size() !== 8) $display("FAIL conflict_beats got %0d want 8", ack_log.size()); else passed++;
        for (int i = 0; i < 8 && i < ack_log.size(); i++) begin
            exp_addr = (i < 4) ? 32'h44 + i : 32'h4 + (i - 4);
            total++; if (ack_log[i] !== exp_addr) $display("FAIL conflict_mem_addr[%0d] got %h want %h", i, ack_log[i], exp_addr); else passed++;
        end
    endtask

    task automatic test_wait_states();
        int lat;
        logic [31:0] d;
        logic [31:0] exp_addr;
        clear_logs();
        ack_div = 3;
        do_req(32'h20, lat, d);
        ack_div = 1;
        total++; if (lat !== 14) $display("FAIL wait_latency got %0d want 14", lat); else passed++;
        total++; if (d !== 32'h120) $display("FAIL wait_data got %h want 00000120", d); else passed++;
        total++; if (addr_log.size() !== 12) $display("FAIL wait_req_cycles got %0d want 12", addr_log.size()); else passed++;
        for (int i = 0; i < 12 && i < addr_log.size(); i++) begin
            exp_addr = 32'h20 + i / 3;
            total++; if (addr_log[i] !== exp_addr) $display("FAIL wait_mem_addr[%0d] got %h want %h", i, addr_log[i], exp_addr); else passed++;
        end
    endtask

    task automatic test_flush_idle();
        int lat;
        logic [31:0] d;
        clear_logs();
        @(negedge clk1);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h5;
        #1;
        total++; if (req_ready !== 1'b0) $display("FAIL flush_req_ready got %0b want 0", req_ready); else passed++;
        @(negedge clk1);
        flush = 1'b0; req_valid = 1'b0;
        total++; if (resp_valid !== 1'b0 || mem_req !== 1'b0) $display("FAIL flush_no_accept got v=%0b mreq=%0b want 0 0", resp_valid, mem_req); else passed++;
        do_req(32'h5, lat, d);
        total++; if (lat !== 6 || d !== 32'h105) $display("FAIL flush_refetch got lat=%0d d=%h want lat=6 d=00000105", lat, d); else passed++;
        total++; if (ack_log.size() !== 4) $display("FAIL flush_refill_beats got %0d want 4", ack_log.size()); else passed++;
    endtask

    task automatic test_flush_refill();
        int lat;
        int n;
        logic [31:0] d;
        clear_logs();
        @(negedge clk1);
        req_valid = 1'b1; req_addr = 32'h30;
        @(negedge clk1);
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk1);
        flush = 1'b0;
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk1);
            n++;
        end
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'h130) $display("FAIL flushref_resp got v=%0b d=%h want v=1 d=00000130", resp_valid, resp_data); else passed++;
        total++; if (req_ready !== 1'b0) $display("FAIL flushref_apply_ready got %0b want 0", req_ready); else passed++;
        do_req(32'h30, lat, d);
        total++; if (lat !== 6 || d !== 32'h130) $display("FAIL flushref_remiss got lat=%0d d=%h want lat=6 d=00000130", lat, d); else passed++;
    endtask

    task automatic test_addr_wrap();
        int lat;
        logic [31:0] d;
        clear_logs();
        do_req(32'hFFFF_FFFF, lat, d);
        total++; if (lat !== 6 || d !== 32'h0000_00FF) $display("FAIL wrap_miss got lat=%0d d=%h want lat=6 d=000000ff", lat, d); else passed++;
        total++; if (ack_log.size() < 1 || ack_log[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_first_beat got %h want fffffffc", (ack_log.size() > 0) ? ack_log[0] : 32'hx); else passed++;
        do_req(32'hFFFF_FFFF, lat, d);
        total++; if (lat !== 1 || d !== 32'h0000_00FF) $display("FAIL wrap_hit got lat=%0d d=%h want lat=1 d=000000ff", lat, d); else passed++;
    endtask

    task automatic test_reset_refill();
        int lat;
        logic [31:0] d;
        do_req(32'h5, lat, d);
        clear_logs();
        @(negedge clk1);
        req_valid = 1'b1; req_addr = 32'h45;
        @(negedge clk1);
        req_valid = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        reset = 1'b1;
        @(negedge clk1);
        total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) $display("FAIL rstref_mem_req got %0b addr %h want 0 0", mem_req, mem_addr); else passed++;
        total++; if (ack_log.size() !== 3) $display("FAIL rstref_beats got %0d want 3", ack_log.size()); else passed++;
`ifdef ICACHE_STATS_EN
        total++; if (hit_count !== 32'h0 || miss_count !== 32'h0) $display("FAIL rstref_stats got h=%0d m=%0d want 0 0", hit_count, miss_count); else passed++;
`endif
        reset = 1'b0;
        clear_logs();
        do_req(32'h5, lat, d);
        total++; if (lat !== 6 || d !== 32'h105) $display("FAIL rstref_remiss got lat=%0d d=%h want lat=6 d=00000105", lat, d); else passed++;
        do_req(32'h45, lat, d);
        total++; if (lat !== 6 || d !== 32'h145) $display("FAIL rstref_partial got lat=%0d d=%h want lat=6 d=00000145", lat, d); else passed++;
`ifdef ICACHE_STATS_EN
        total++; if (miss_count !== 32'd2) $display("FAIL stats_miss got %0d want 2", miss_count); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_streak();
        test_conflict();
        test_wait_states();
        test_flush_idle();
        test_flush_refill();
        test_addr_wrap();
        test_reset_refill();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
